// File: rtl/kamacore_muldiv_alu.sv
// kamacore_muldiv_alu
//   Integer execute unit. It covers the RV32 OP-IMM and OP groups and, when
//   built with KAMACORE_MULDIV_EN defined, the M extension. Multiply and
//   divide are iterative and retire one bit per cycle. Every other accepted
//   op completes with a latency of one cycle. Any unsupported encoding
//   completes with a zero result and illegal=1.
//
//   Build macro: KAMACORE_MULDIV_EN
//     defined   - funct7=0000001 runs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
//     undefined - funct7=0000001 is reported as illegal, and no mul/div
//                 datapath is built
//
//   Ports
//     clk, rst             clock, synchronous active-high reset
//     in_valid/in_ready    request handshake; in_ready is high only in IDLE
//     instruction          RV32 word (opcode [6:0], funct3 [14:12], funct7 [31:25])
//     source1, source2     rs1 / rs2 operand values
//     imm32i               sign-extended I-type immediate
//     out_valid/out_ready  result handshake
//     alu_result, illegal  result and unsupported-encoding flag, held in DONE
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a request, in_ready=1
//   BUSY  | iterating mul/div, one bit per cycle, cnt counts down
//   DONE  | result valid and held until out_ready
module kamacore_muldiv_alu #(
    parameter int CPU_WIDTH = 32,
    parameter int SHAMT_W   = $clog2(CPU_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instruction,
    input  logic [CPU_WIDTH-1:0] source1,
    input  logic [CPU_WIDTH-1:0] source2,
    input  logic [CPU_WIDTH-1:0] imm32i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CPU_WIDTH-1:0] alu_result,
    output logic                 illegal
);

    localparam int W     = CPU_WIDTH;
    localparam int CNT_W = SHAMT_W + 1;

    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [6:0]   funct7;
    logic [2:0]   funct3;
    logic         is_opimm, is_op, alt_f7;
    logic         accept;
    logic [W-1:0] op_b, base_res;
    logic [SHAMT_W-1:0] shamt;
    logic         base_legal, m_req;
    logic         unused_insn;

    assign funct7    = instruction[31:25];
    assign funct3    = instruction[14:12];
    assign is_opimm  = (instruction[6:0] == OPC_OPIMM);
    assign is_op     = (instruction[6:0] == OPC_OP);
    assign alt_f7    = (funct7 == F7_ALT);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign unused_insn = ^{instruction[24:15], instruction[11:7]};

    always_comb begin
        op_b       = is_opimm ? imm32i : source2;
        shamt      = op_b[SHAMT_W-1:0];
        base_legal = 1'b0;
        m_req      = 1'b0;
        base_res   = '0;
        if (is_opimm) begin
            // funct7 is immediate bits here; it is only constrained for shifts
            case (funct3)
                3'b001:  base_legal = (funct7 == F7_BASE);
                3'b101:  base_legal = (funct7 == F7_BASE) || alt_f7;
                default: base_legal = 1'b1;
            endcase
        end else if (is_op) begin
            if (funct7 == F7_BASE)
                base_legal = 1'b1;
            else if (alt_f7)
                base_legal = (funct3 == 3'b000) || (funct3 == 3'b101);
`ifdef KAMACORE_MULDIV_EN
            else if (funct7 == F7_MULDIV)
                m_req = 1'b1;
`endif
        end
        case (funct3)
            3'b000:  base_res = (is_op && alt_f7) ? source1 - op_b : source1 + op_b;
            3'b001:  base_res = source1 << shamt;
            3'b010:  base_res = {{(W-1){1'b0}}, ($signed(source1) < $signed(op_b))};
            3'b011:  base_res = {{(W-1){1'b0}}, (source1 < op_b)};
            3'b100:  base_res = source1 ^ op_b;
            3'b101:  base_res = alt_f7 ? $unsigned($signed(source1) >>> shamt) : source1 >> shamt;
            3'b110:  base_res = source1 | op_b;
            default: base_res = source1 & op_b;
        endcase
        if (!base_legal)
            base_res = '0;
    end

`ifdef KAMACORE_MULDIV_EN
    // acc holds {product_hi, multiplier} for multiply and {remainder, dividend/quotient} for divide
    logic [2*W-1:0] acc, acc_step, prod;
    logic [W-1:0]   opb, a_mag, b_mag, quo, rem, m_res;
    logic [W:0]     mul_sum, div_shift;
    logic [W+1:0]   div_diff;
    logic [2:0]     m_f3;
    logic [CNT_W-1:0] cnt;
    logic           res_neg, rem_neg;
    logic           a_signed, b_signed, a_neg, b_neg;
    logic           unused_div;

    assign unused_div = div_diff[W];

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            3'b010:  a_signed = 1'b1;
            default: ;
        endcase
        a_neg = a_signed & source1[W-1];
        b_neg = b_signed & source2[W-1];
        a_mag = a_neg ? -source1 : source1;
        b_mag = b_neg ? -source2 : source2;

        mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opb} : {(W+1){1'b0}});
        div_shift = {acc[2*W-1:W], acc[W-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opb};
        if (!m_f3[2])
            acc_step = {mul_sum, acc[W-1:1]};
        else if (!div_diff[W+1])
            acc_step = {div_diff[W-1:0], acc[W-2:0], 1'b1};
        else
            acc_step = {div_shift[W-1:0], acc[W-2:0], 1'b0};

        prod = res_neg ? -acc_step : acc_step;
        quo  = acc_step[W-1:0];
        rem  = acc_step[2*W-1:W];
        if (!m_f3[2])
            m_res = (m_f3[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
        else if (!m_f3[1])
            m_res = res_neg ? -quo : quo;
        else
            m_res = rem_neg ? -rem : rem;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = m_req ? BUSY : DONE;
`ifdef KAMACORE_MULDIV_EN
            BUSY: if (cnt == CNT_W'(1)) state_next = DONE;
`else
            BUSY: state_next = IDLE;
`endif
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_result <= '0;
            illegal    <= 1'b0;
`ifdef KAMACORE_MULDIV_EN
            cnt     <= '0;
            acc     <= '0;
            opb     <= '0;
            m_f3    <= '0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
`endif
        end else begin
            if (accept) begin
`ifdef KAMACORE_MULDIV_EN
                if (m_req) begin
                    illegal <= 1'b0;
                    cnt     <= CNT_W'(W);
                    acc     <= {{W{1'b0}}, a_mag};
                    opb     <= b_mag;
                    m_f3    <= funct3;
                    // divide by zero keeps the all-ones quotient unsigned
                    res_neg <= funct3[2] ? ((a_neg ^ b_neg) && (source2 != '0)) : (a_neg ^ b_neg);
                    rem_neg <= a_neg;
                end else
`endif
                begin
                    alu_result <= base_res;
                    illegal    <= ~base_legal;
                end
            end
`ifdef KAMACORE_MULDIV_EN
            if (state == BUSY) begin
                acc <= acc_step;
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1))
                    alu_result <= m_res;
            end
`endif
        end
    end

endmodule

// File: tb/tb_kamacore_muldiv_alu.sv
module tb_kamacore_muldiv_alu;

`ifdef KAMACORE_MULDIV_EN
    localparam bit MD_ON = 1'b1;
`else
    localparam bit MD_ON = 1'b0;
`endif

    logic        clk, rst, in_valid, in_ready, out_valid, out_ready, illegal;
    logic [31:0] instruction, source1, source2, imm32i, alu_result;

    int errors = 0;
    int checks = 0;

    kamacore_muldiv_alu dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .source1(source1), .source2(source2),
        .imm32i(imm32i), .out_valid(out_valid), .out_ready(out_ready),
        .alu_result(alu_result), .illegal(illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_r(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    function automatic logic [31:0] mk_i(input logic [11:0] imm, input logic [2:0] f3);
        return {imm, 5'd1, f3, 5'd3, 7'b0010011};
    endfunction

    // Reference: what the result must be, from RISC-V semantics
    function automatic void model(input logic [31:0] ins, input logic [31:0] a,
                                  input logic [31:0] b2, input logic [31:0] imm,
                                  output logic [31:0] res, output logic ill, output int lat);
        logic [6:0]  opc, f7;
        logic [2:0]  f3;
        logic [31:0] b;
        logic [63:0] p;
        int          sa, sb, sh;
        bit          legal, ovf;
        opc = ins[6:0];
        f7  = ins[31:25];
        f3  = ins[14:12];
        b   = (opc == 7'h13) ? imm : b2;
        sa  = a;
        sb  = b;
        sh  = int'(b[4:0]);
        res = 32'h0;
        ill = 1'b1;
        lat = 1;
        legal = 1'b0;
        if (opc == 7'h13)
            legal = (f3 == 3'd1) ? (f7 == 7'h00) : (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        else if (opc == 7'h33)
            legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        if (legal) begin
            ill = 1'b0;
            case (f3)
                3'd0: res = (opc == 7'h33 && f7 == 7'h20) ? a - b : a + b;
                3'd1: res = a << sh;
                3'd2: res = (sa < sb) ? 32'd1 : 32'd0;
                3'd3: res = (a < b) ? 32'd1 : 32'd0;
                3'd4: res = a ^ b;
                3'd5: res = (f7 == 7'h20) ? 32'(sa >>> sh) : a >> sh;
                3'd6: res = a | b;
                default: res = a & b;
            endcase
        end else if (opc == 7'h33 && f7 == 7'h01 && MD_ON) begin
            ill = 1'b0;
            lat = 33;
            ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
            case (f3)
                3'd0: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; res = p[31:0];  end
                3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; res = p[63:32]; end
                3'd2: begin p = {{32{a[31]}}, a} * {32'h0, b};       res = p[63:32]; end
                3'd3: begin p = {32'h0, a} * {32'h0, b};             res = p[63:32]; end
                3'd4: res = (b == 0) ? 32'hFFFFFFFF : ovf ? a : 32'(sa / sb);
                3'd5: res = (b == 0) ? 32'hFFFFFFFF : a / b;
                3'd6: res = (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
                default: res = (b == 0) ? a : a % b;
            endcase
        end
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] rand_ins();
        int r;
        logic [2:0]  f3;
        logic [4:0]  sh;
        logic [11:0] imm12;
        r     = $urandom_range(0, 19);
        f3    = 3'($urandom_range(0, 7));
        sh    = 5'($urandom);
        imm12 = 12'($urandom);
        if (r < 7) begin
            if (r != 0 && f3 == 3'd1) imm12 = {7'h00, sh};
            if (r != 0 && f3 == 3'd5) imm12 = {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, sh};
            return mk_i(imm12, f3);
        end
        if (r < 12) return mk_r(($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, f3);
        if (r < 18) return mk_r(7'h01, f3);
        if (r == 18) return mk_r(7'($urandom), f3);
        return $urandom;
    endfunction

    // Cycle monitor: tracks the one outstanding op and checks the DUT on every negedge
    initial begin
        int          cyc, due, lat;
        bit          armed, rst_seen, pend;
        logic [31:0] e_res, m_res;
        logic        e_ill, m_ill;
        cyc = 0; due = 0; armed = 0; rst_seen = 0; pend = 0;
        e_res = 0; e_ill = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (armed) begin
                if (rst_seen) begin
                    chk("reset_result", alu_result, 0);
                    chk("reset_illegal", illegal, 0);
                end
                if (!pend) begin
                    chk("idle_in_ready", in_ready, 1);
                    chk("idle_out_valid", out_valid, 0);
                end else if (cyc < due) begin
                    chk("busy_in_ready", in_ready, 0);
                    chk("busy_out_valid", out_valid, 0);
                end else begin
                    chk("done_out_valid", out_valid, 1);
                    chk("done_in_ready", in_ready, 0);
                    chk("done_result", alu_result, e_res);
                    chk("done_illegal", illegal, e_ill);
                end
            end
            rst_seen = 0;
            if (rst) begin
                pend = 0;
                armed = 1;
                rst_seen = 1;
            end else if (armed) begin
                if (pend && cyc >= due && out_ready) begin
                    pend = 0;
                end else if (!pend && in_valid) begin
                    model(instruction, source1, source2, imm32i, m_res, m_ill, lat);
                    e_res = m_res;
                    e_ill = m_ill;
                    due = cyc + lat;
                    pend = 1;
                end
            end
        end
    end

    task automatic run_op(input string nm, input logic [31:0] ins, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] imm,
                          input logic [31:0] exp_res, input logic exp_ill, input int exp_lat);
        int n;
        bit got, rdy_seen;
        @(posedge clk); #1;
        instruction = ins; source1 = a; source2 = b; imm32i = imm;
        in_valid = 1; out_ready = 1;
        @(posedge clk); #1;
        in_valid = 0;
        instruction = $urandom; source1 = $urandom; source2 = $urandom; imm32i = $urandom;
        n = 1; got = 0; rdy_seen = 0;
        while (!got && n <= 100) begin
            if (out_valid) got = 1;
            else begin
                if (in_ready) rdy_seen = 1;
                @(posedge clk); #1;
                n++;
            end
        end
        chk({nm, "_latency"}, n, exp_lat);
        chk({nm, "_result"}, alu_result, exp_res);
        chk({nm, "_illegal"}, illegal, exp_ill);
        chk({nm, "_busy_ready"}, rdy_seen, 0);
    endtask

    task automatic run_m(input string nm, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res);
        run_op(nm, mk_r(7'h01, f3), a, b, $urandom, MD_ON ? exp_res : 32'h0, !MD_ON, MD_ON ? 33 : 1);
    endtask

    initial begin
        logic [31:0] r;
        logic        il;
        int          lt;
        bit          seen;

        rst = 1; in_valid = 0; out_ready = 1;
        instruction = 0; source1 = 0; source2 = 0; imm32i = 0;

        // pin the reference model with hand-computed values
        model(mk_i(12'hFFD, 3'd0), 32'h5, 32'h0, 32'hFFFFFFFD, r, il, lt);
        chk("model_addi", r, 32'h2);
        model(mk_r(7'h20, 3'd5), 32'h80000000, 32'h24, 32'h0, r, il, lt);
        chk("model_sra", r, 32'hF8000000);
        model(mk_r(7'h20, 3'd2), 32'h1, 32'h2, 32'h0, r, il, lt);
        chk("model_bad_f7", {r, 31'h0, il}, {32'h0, 32'h1});
`ifdef KAMACORE_MULDIV_EN
        model(mk_r(7'h01, 3'd1), 32'hFFFFFFFF, 32'h2, 32'h0, r, il, lt);
        chk("model_mulh", {r, 32'(lt)}, {32'hFFFFFFFF, 32'd33});
        model(mk_r(7'h01, 3'd4), 32'hFFFFFFF9, 32'h2, 32'h0, r, il, lt);
        chk("model_div_neg", r, 32'hFFFFFFFD);
        model(mk_r(7'h01, 3'd6), 32'h80000000, 32'hFFFFFFFF, 32'h0, r, il, lt);
        chk("model_rem_ovf", r, 32'h0);
`else
        model(mk_r(7'h01, 3'd0), 32'h3, 32'h3, 32'h0, r, il, lt);
        chk("model_mul_off", {r, 31'h0, il}, {32'h0, 32'h1});
`endif

        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(posedge clk); #1;
        chk("ready_after_reset", in_ready, 1);

        run_op("addi",    mk_i(12'hFFD, 3'd0), 32'h5, 32'h0, 32'hFFFFFFFD, 32'h2, 0, 1);
        run_op("sra",     mk_r(7'h20, 3'd5), 32'h80000000, 32'h24, 32'h0, 32'hF8000000, 0, 1);
        run_op("sltu",    mk_r(7'h00, 3'd3), 32'h1, 32'hFFFFFFFF, 32'h0, 32'h1, 0, 1);
        run_op("slt",     mk_r(7'h00, 3'd2), 32'h1, 32'hFFFFFFFF, 32'h0, 32'h0, 0, 1);
        run_op("slli",    mk_i(12'h01F, 3'd1), 32'h1, 32'h0, 32'h1F, 32'h80000000, 0, 1);
        run_op("sub",     mk_r(7'h20, 3'd0), 32'h3, 32'h5, 32'h0, 32'hFFFFFFFE, 0, 1);
        run_op("bad_opc", 32'h0000007F, 32'h1, 32'h2, 32'h3, 32'h0, 1, 1);
        run_op("bad_f7",  mk_r(7'h20, 3'd2), 32'h1, 32'h2, 32'h0, 32'h0, 1, 1);
        run_m("mulh",    3'd1, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF);
        run_m("mul",     3'd0, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001);
        run_m("mulhu",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_m("mulhsu",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_m("div_by0", 3'd4, 32'h7, 32'h0, 32'hFFFFFFFF);
        run_m("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0);
        run_m("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run_m("div_neg", 3'd4, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD);
        run_m("rem_neg", 3'd6, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF);
        run_m("remu_by0", 3'd7, 32'h7, 32'h0, 32'h7);
        run_m("divu",    3'd5, 32'hFFFFFFFF, 32'd10, 32'h19999999);

        // back-pressure: result held, second request ignored
        @(posedge clk); #1;
        instruction = mk_r(7'h00, 3'd0); source1 = 1; source2 = 1;
        in_valid = 1; out_ready = 0;
        @(posedge clk); #1;
        instruction = mk_r(7'h20, 3'd0); source1 = 32'h55; source2 = 32'h7;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_result", alu_result, 32'h2);
            chk("bp_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        in_valid = 0; out_ready = 1;
        @(posedge clk); #1;
        chk("bp_retired", {in_ready, out_valid}, 2'b10);

        // reset in the middle of a DIVU
        instruction = mk_r(7'h01, 3'd5); source1 = 32'd1000; source2 = 32'd7;
        in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (9) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("abort_in_ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        chk("abort_no_valid", seen, 0);

        // random traffic, the monitor checks every cycle
        for (int c = 0; c < 6000; c++) begin
            @(posedge clk); #1;
            instruction = rand_ins();
            source1 = pick();
            source2 = pick();
            imm32i  = (instruction[6:0] == 7'h13) ? {{20{instruction[31]}}, instruction[31:20]} : pick();
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 70);
            rst       = ($urandom_range(0, 999) < 4);
        end
        @(posedge clk); #1;
        rst = 0; in_valid = 0; out_ready = 1;
        repeat (50) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/kamacore_muldiv_alu.md
KAMACORE_MULDIV_ALU -- requirements
Module: kamacore_muldiv_alu

Interface
REQ-001 The block SHALL have parameter CPU_WIDTH, default 32, datapath width in bits (power of two, 8..64).
REQ-002 The block SHALL have parameter SHAMT_W, default $clog2(CPU_WIDTH), shift-amount width.
REQ-003 The block SHALL run on one clock and use a synchronous, active-high reset.
REQ-004 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-005 Port: rst  in  1  synchronous active-high reset.
REQ-006 Port: in_valid  in  1  operation request present.
REQ-007 Port: in_ready  out  1  block can accept a request.
REQ-008 Port: instruction  in  32  RV32 instruction word (opcode [6:0], funct3 [14:12], funct7 [31:25]).
REQ-009 Port: source1, source2  in  CPU_WIDTH  rs1 and rs2 operand values.
REQ-010 Port: imm32i  in  CPU_WIDTH  sign-extended I-type immediate.
REQ-011 Port: out_valid  out  1  result present.
REQ-012 Port: out_ready  in  1  consumer takes result.
REQ-013 Port: alu_result  out  CPU_WIDTH  operation result, held stable while out_valid=1.
REQ-014 Port: illegal  out  1  unsupported encoding; qualified by out_valid.

Function
REQ-015 FSM states SHALL be IDLE, BUSY and DONE; in_ready=1 only in IDLE.
REQ-016 Accept occurs on in_valid&&in_ready; operands, immediate and decoded op SHALL be latched at accept and ignored afterwards.
REQ-017 OP-IMM (0010011) SHALL implement ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI, with imm32i as operand 2.
REQ-018 OP (0110011, funct7 0000000/0100000) SHALL implement ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
REQ-019 Shift amount SHALL be operand2[SHAMT_W-1:0]; add/sub SHALL wrap modulo 2^CPU_WIDTH; SLT/SLTU SHALL return 0 or 1 zero-extended.
REQ-020 Base ops SHALL go IDLE->DONE at accept; out_valid asserts the cycle after accept (latency 1).
REQ-021 OP with funct7 0000001 (M ops) SHALL go IDLE->BUSY and take exactly CPU_WIDTH BUSY cycles, then BUSY->DONE; out_valid asserts CPU_WIDTH+1 cycles after accept.
REQ-022 MUL/MULH/MULHSU/MULHU SHALL use an iterative shift-add of one bit per cycle on magnitudes with final sign fix-up, returning the low or high CPU_WIDTH bits of the 2*CPU_WIDTH product.
REQ-023 DIV/DIVU/REM/REMU SHALL use a restoring divider of one quotient bit per cycle; signed results truncate toward zero and the remainder takes the dividend's sign.
REQ-024 Divide by zero SHALL return quotient all-ones and remainder = dividend, with no exception; it still takes CPU_WIDTH BUSY cycles.
REQ-025 Signed overflow (most-negative / -1) SHALL return quotient = dividend and remainder = 0.
REQ-026 Any other opcode, funct7 or funct3 combination SHALL go to DONE at latency 1 with alu_result=0 and illegal=1; otherwise illegal=0.
REQ-027 DONE SHALL hold alu_result and illegal stable until out_valid&&out_ready, then go DONE->IDLE.
REQ-028 in_ready SHALL stay 0 in the DONE completion cycle; no same-cycle accept and retire.
REQ-029 in_valid while BUSY or DONE SHALL be ignored with no state change.

Reset
REQ-030 While rst=1 at a clock edge, the state SHALL become IDLE, out_valid=0, alu_result=0, illegal=0 and the iteration counter=0.
REQ-031 Reset during BUSY or DONE SHALL abort the operation and discard its result, with no out_valid pulse afterwards.
REQ-032 in_ready SHALL be 1 from the first edge after rst deasserts.

Configuration
REQ-033 Macro KAMACORE_MULDIV_EN defined: M ops SHALL behave per REQ-021..REQ-025.
REQ-034 Macro KAMACORE_MULDIV_EN undefined: funct7 0000001 SHALL be treated per REQ-026 (latency 1, result 0, illegal=1), and no multiplier or divider logic SHALL be synthesised.

Verification
REQ-035 ADDI, source1=0x00000005, imm32i=0xFFFFFFFD, out_ready=1 -> out_valid one cycle after accept, alu_result=0x00000002, illegal=0.
REQ-036 SRA, source1=0x80000000, source2=0x00000024 -> shift of 4, alu_result=0xF8000000.
REQ-037 MULH (macro on), source1=0xFFFFFFFF, source2=0x00000002 -> alu_result=0xFFFFFFFF exactly 33 cycles after accept; in_ready=0 throughout.
REQ-038 DIV (macro on), source2=0, source1=0x00000007 -> 0xFFFFFFFF; REM with 0x80000000 / 0xFFFFFFFF -> 0x00000000.
REQ-039 Back-pressure: ADD 1+1 with out_ready=0 for 5 cycles -> out_valid=1 and alu_result=0x00000002 stable, in_ready=0, second in_valid ignored.
REQ-040 rst pulse 10 cycles into DIVU -> next cycle IDLE, in_ready=1, out_valid never asserts for the aborted op; a macro-off build returns illegal=1 and result 0 for MUL.
